// File: rtl/cursor_hid_report_pkg.sv
// Shared definitions for the cursor HID report path: FSM encoding, report
// framing constants and the saturation helpers used by both axes.
package cursor_hid_report_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_B0,
    ST_B1,
    ST_B2
  } state_e;

  localparam int REPORT_LEN = 3;
  localparam int INT8_LIM   = 127;
  localparam int ACC_W      = 24;
  localparam int SUM_W      = ACC_W + 2;
  localparam int ACC_MAX    = (1 << (ACC_W - 1)) - 1;

  // Symmetric int8 clamp; -128 is never emitted.
  function automatic logic signed [7:0] clamp_i8(input logic signed [ACC_W-1:0] v);
    if (int'(v) > INT8_LIM) begin
      return 8'sd127;
    end else if (int'(v) < -INT8_LIM) begin
      return -8'sd127;
    end else begin
      return 8'(v);
    end
  endfunction

  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [SUM_W-1:0] v);
    if (int'(v) > ACC_MAX) begin
      return ACC_W'(ACC_MAX);
    end else if (int'(v) < -ACC_MAX) begin
      return ACC_W'(-ACC_MAX);
    end else begin
      return ACC_W'(v);
    end
  endfunction

endpackage

// File: rtl/cursor_axis_accum.sv
// One motion axis: tick-to-tick delta with deadzone, saturating accumulator,
// gain shift with int8 clamp, and removal of the emitted amount on CALC.
module cursor_axis_accum
  import cursor_hid_report_pkg::*;
#(
  parameter int GAIN_SHIFT = 2,
  parameter int DEADZONE   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_tick,
  input  logic               i_primed,
  input  logic               i_calc,
  input  logic signed [15:0] i_mu,
  output logic signed [7:0]  o_e
);

  logic signed [15:0]      r_prev;
  logic signed [ACC_W-1:0] r_acc;

  logic signed [16:0]      w_delta;
  logic        [16:0]      w_mag;
  logic signed [16:0]      w_d;
  logic signed [ACC_W-1:0] w_scaled;
  logic signed [ACC_W-1:0] w_sub;
  logic signed [SUM_W-1:0] w_sum;

  assign w_delta  = 17'(i_mu) - 17'(r_prev);
  assign w_mag    = w_delta[16] ? 17'(-w_delta) : 17'(w_delta);
  assign w_d      = (!(i_tick && i_primed) || (w_mag <= 17'(DEADZONE))) ? '0 : w_delta;

  // The emitted value is taken from the pre-tick accumulator; a tick landing
  // in the same cycle is added on top of the residual.
  assign w_scaled = r_acc >>> GAIN_SHIFT;
  assign o_e      = clamp_i8(w_scaled);
  assign w_sub    = i_calc ? (ACC_W'(o_e) <<< GAIN_SHIFT) : '0;
  assign w_sum    = SUM_W'(r_acc) - SUM_W'(w_sub) + SUM_W'(w_d);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev <= '0;
      r_acc  <= '0;
    end else begin
      if (i_tick) r_prev <= i_mu;
      r_acc <= sat_acc(w_sum);
    end
  end

endmodule

// File: rtl/cursor_hid_report.sv
// Turns filtered cursor position into 3-byte relative HID reports
// ({btn}, dx, dy) on a ready/valid byte stream, one report per tick.
module cursor_hid_report
  import cursor_hid_report_pkg::*;
#(
  parameter int GAIN_SHIFT = 2,
  parameter int DEADZONE   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] mu_x_f,
  input  logic signed [15:0] mu_y_f,
  input  logic               report_tick,
  input  logic [1:0]         btn,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               tx_last,
  output logic [7:0]         drop_cnt
);

  state_e      r_state;
  logic        r_primed;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;
  logic        r_tx_last;
  logic [7:0]  r_dx;
  logic [7:0]  r_dy;
  logic [7:0]  r_drop;
  logic [1:0]  r_last_btn;

  logic              w_ptick;
  logic              w_calc;
  logic signed [7:0] w_ex;
  logic signed [7:0] w_ey;

  assign w_ptick = report_tick && r_primed;
  assign w_calc  = (r_state == ST_CALC);

  cursor_axis_accum #(
    .GAIN_SHIFT(GAIN_SHIFT),
    .DEADZONE  (DEADZONE)
  ) u_axis_x (
    .clk     (clk),
    .rst     (rst),
    .i_tick  (report_tick),
    .i_primed(r_primed),
    .i_calc  (w_calc),
    .i_mu    (mu_x_f),
    .o_e     (w_ex)
  );

  cursor_axis_accum #(
    .GAIN_SHIFT(GAIN_SHIFT),
    .DEADZONE  (DEADZONE)
  ) u_axis_y (
    .clk     (clk),
    .rst     (rst),
    .i_tick  (report_tick),
    .i_primed(r_primed),
    .i_calc  (w_calc),
    .i_mu    (mu_y_f),
    .o_e     (w_ey)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_primed   <= 1'b0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_tx_last  <= 1'b0;
      r_dx       <= '0;
      r_dy       <= '0;
      r_drop     <= '0;
      r_last_btn <= 2'b00;
    end else begin
      if (report_tick) r_primed <= 1'b1;
      // Any primed tick outside IDLE is lost as a report trigger, including
      // one that coincides with the final handshake.
      if (w_ptick && (r_state != ST_IDLE) && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;

      case (r_state)
        ST_IDLE: if (w_ptick) r_state <= ST_CALC;
        ST_CALC: begin
          r_dx <= w_ex;
          r_dy <= w_ey;
          if ((w_ex == 8'sd0) && (w_ey == 8'sd0) && (btn == r_last_btn)) begin
            r_state <= ST_IDLE;
          end else begin
            r_state    <= ST_B0;
            r_tx_valid <= 1'b1;
            r_tx_data  <= {6'b0, btn};
            r_tx_last  <= 1'b0;
          end
        end
        ST_B0: if (tx_ready) begin
          r_last_btn <= r_tx_data[1:0];
          r_tx_data  <= r_dx;
          r_state    <= ST_B1;
        end
        ST_B1: if (tx_ready) begin
          r_tx_data <= r_dy;
          r_tx_last <= 1'b1;
          r_state   <= ST_B2;
        end
        ST_B2: if (tx_ready) begin
          r_tx_valid <= 1'b0;
          r_tx_last  <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign tx_last  = r_tx_last;
  assign drop_cnt = r_drop;

endmodule

// File: tb/tb_cursor_hid_report.sv
// Bench for cursor_hid_report: an arithmetic report model checked every cycle,
// plus directed scenarios with hand-computed report bytes.
module tb_cursor_hid_report;

  localparam int GAIN = 2;
  localparam int DZ   = 2;

  logic               clk;
  logic               rst;
  logic signed [15:0] mu_x_f;
  logic signed [15:0] mu_y_f;
  logic               report_tick;
  logic [1:0]         btn;
  logic [7:0]         tx_data;
  logic               tx_valid;
  logic               tx_ready;
  logic               tx_last;
  logic [7:0]         drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [8:0] got[$];

  cursor_hid_report #(
    .GAIN_SHIFT(GAIN),
    .DEADZONE  (DZ)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mu_x_f     (mu_x_f),
    .mu_y_f     (mu_y_f),
    .report_tick(report_tick),
    .btn        (btn),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_last    (tx_last),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int dz(input int d);
    return (d <= DZ && d >= -DZ) ? 0 : d;
  endfunction

  function automatic int clamp127(input int v);
    return (v > 127) ? 127 : ((v < -127) ? -127 : v);
  endfunction

  function automatic int sat23(input int v);
    return (v > 8388607) ? 8388607 : ((v < -8388607) ? -8388607 : v);
  endfunction

  int         m_phase;  // 0 waiting, 1 computing, 2 sending
  int         m_accx, m_accy, m_prevx, m_prevy, m_idx, m_drop;
  int         m_dx, m_dy, m_ex, m_ey;
  bit         m_primed, m_pt;
  logic [1:0] m_last;
  logic [7:0] m_bytes[3];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_accx = 0; m_accy = 0; m_prevx = 0; m_prevy = 0;
      m_idx = 0; m_drop = 0; m_primed = 0; m_last = 2'b00;
    end else begin
      m_pt = report_tick && m_primed;
      m_dx = m_pt ? dz(int'(mu_x_f) - m_prevx) : 0;
      m_dy = m_pt ? dz(int'(mu_y_f) - m_prevy) : 0;
      m_ex = 0;
      m_ey = 0;
      if (m_phase == 1) begin
        m_ex = clamp127(m_accx >>> GAIN);
        m_ey = clamp127(m_accy >>> GAIN);
        m_accx = m_accx - m_ex * (1 << GAIN);
        m_accy = m_accy - m_ey * (1 << GAIN);
      end
      m_accx = sat23(m_accx + m_dx);
      m_accy = sat23(m_accy + m_dy);
      if (m_pt && m_phase != 0 && m_drop < 255) m_drop++;
      if (report_tick) begin
        m_prevx = int'(mu_x_f);
        m_prevy = int'(mu_y_f);
        m_primed = 1;
      end
      case (m_phase)
        0: if (m_pt) m_phase = 1;
        1: if (m_ex == 0 && m_ey == 0 && btn == m_last) m_phase = 0;
           else begin
             m_bytes[0] = {6'b0, btn};
             m_bytes[1] = 8'(m_ex);
             m_bytes[2] = 8'(m_ey);
             m_idx = 0;
             m_phase = 2;
           end
        default: if (tx_ready) begin
          if (m_idx == 0) m_last = m_bytes[0][1:0];
          if (m_idx == 2) m_phase = 0;
          else m_idx++;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("model_valid", tx_valid, m_phase == 2);
      check("model_last", tx_last, (m_phase == 2) && (m_idx == 2));
      check("model_drop", drop_cnt, m_drop);
      if (m_phase == 2) check("model_data", tx_data, m_bytes[m_idx]);
    end
  end

  always @(posedge clk) begin
    if (!rst && tx_valid && tx_ready) got.push_back({tx_last, tx_data});
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick(input int x, input int y);
    @(negedge clk);
    mu_x_f = 16'(x);
    mu_y_f = 16'(y);
    report_tick = 1'b1;
    @(negedge clk);
    report_tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    report_tick = 1'b0;
    idle(2);
    rst = 1'b0;
    got.delete();
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 20; i++) begin
      if (tx_valid) break;
      @(negedge clk);
    end
    check(name, tx_valid, 1'b1);
  endtask

  task automatic expect_report(input string name, input logic [7:0] b0,
                               input logic [7:0] b1, input logic [7:0] b2);
    for (int i = 0; i < 40; i++) begin
      if (got.size() >= 3) break;
      @(negedge clk);
    end
    check({name, "_nbytes"}, got.size(), 3);
    if (got.size() >= 3) begin
      check({name, "_b0"}, got[0], {1'b0, b0});
      check({name, "_b1"}, got[1], {1'b0, b1});
      check({name, "_b2"}, got[2], {1'b1, b2});
    end
    got.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    rst = 1'b1;
    mu_x_f = '0;
    mu_y_f = '0;
    report_tick = 1'b0;
    btn = 2'b00;
    tx_ready = 1'b1;
    idle(3);
    check("rst_valid", tx_valid, 1'b0);
    check("rst_last", tx_last, 1'b0);
    check("rst_data", tx_data, 8'h00);
    check("rst_drop", drop_cnt, 8'h00);
    rst = 1'b0;

    // Basic report and first-byte latency.
    tick(0, 0);
    idle(4);
    check("prime_no_report", got.size(), 0);
    @(negedge clk);
    mu_x_f = 16'sd40;
    mu_y_f = -16'sd8;
    report_tick = 1'b1;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      report_tick = 1'b0;
      lat++;
      if (tx_valid) break;
    end
    check("latency", lat, 2);
    expect_report("basic", 8'h00, 8'h0A, 8'hFE);

    // Deadzone suppression, then a button-only report.
    do_reset();
    tick(0, 0);
    tick(2, 0);
    idle(8);
    check("deadzone_no_report", got.size(), 0);
    btn = 2'b01;
    tick(2, 0);
    expect_report("btn_only", 8'h01, 8'h00, 8'h00);

    // Large motion: clamp, then residual drains; same in the negative direction.
    do_reset();
    btn = 2'b00;
    tick(0, 0);
    tick(1000, 0);
    expect_report("clamp_pos", 8'h00, 8'h7F, 8'h00);
    tick(1000, 0);
    expect_report("resid_pos", 8'h00, 8'h7B, 8'h00);
    tick(1000, 0);
    idle(8);
    check("resid_drained", got.size(), 0);
    tick(0, 0);
    expect_report("clamp_neg", 8'h00, 8'h81, 8'h00);
    tick(0, 0);
    expect_report("resid_neg", 8'h00, 8'h85, 8'h00);

    // Backpressure in B1 with three dropped ticks.
    do_reset();
    tick(0, 0);
    tx_ready = 1'b0;
    tick(40, 0);
    wait_valid("stall_b0_valid");
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      report_tick = (i == 1 || i == 4 || i == 7);
      if (report_tick) mu_x_f = mu_x_f + 16'sd20;
      @(negedge clk);
      check("stall_data", tx_data, 8'h0A);
      check("stall_valid", tx_valid, 1'b1);
    end
    report_tick = 1'b0;
    check("stall_drop", drop_cnt, 8'd3);
    tx_ready = 1'b1;
    expect_report("stalled", 8'h00, 8'h0A, 8'h00);
    tick(100, 0);
    expect_report("after_stall", 8'h00, 8'h0F, 8'h00);

    // Reset in the middle of a transfer.
    do_reset();
    tick(0, 0);
    tx_ready = 1'b0;
    tick(40, 0);
    wait_valid("abort_b0_valid");
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    tick(60, 0);
    check("abort_drop_before", drop_cnt, 8'd1);
    rst = 1'b1;
    #1;
    check("abort_valid", tx_valid, 1'b0);
    check("abort_drop", drop_cnt, 8'd0);
    check("abort_last", tx_last, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    got.delete();
    tx_ready = 1'b1;
    tick(40, 0);
    idle(8);
    check("abort_reprime", got.size(), 0);
    tick(80, 0);
    expect_report("after_abort", 8'h00, 8'h0A, 8'h00);

    idle(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
